// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter slice.
// Defaults are also used by the downstream fifo_sync instantiation.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int NB_DEF        = 8;
    localparam int NR_DEF        = 4;
    localparam int LG_DEF        = 2;
    localparam int MB_DEF        = 4;
    localparam int BURST_MAX_DEF = 8;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-side write handshakes of the arbiter.
// master = arbiter view, slave = environment view.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int Nb = NB_DEF,
    parameter int Nr = NR_DEF
);

    logic [Nr-1:0]    in_valid;
    logic [Nr*Nb-1:0] in_data;
    logic [Nr-1:0]    in_ready;
    logic             fifo_wr_valid;
    logic [Nb-1:0]    fifo_wr_data;
    logic             fifo_wr_ready;

    modport master (
        input  in_valid, in_data, fifo_wr_ready,
        output in_ready, fifo_wr_valid, fifo_wr_data
    );

    modport slave (
        output in_valid, in_data, fifo_wr_ready,
        input  in_ready, fifo_wr_valid, fifo_wr_data
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first request above last,
// wrapping to index 0; works for any Nr (not only powers of two).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int Nr = NR_DEF,
    parameter int Lg = LG_DEF
) (
    input  logic [Nr-1:0] req,
    input  logic [Lg-1:0] last,
    output logic [Lg-1:0] pick,
    output logic          any
);

    logic hi_found;
    logic [Lg-1:0] hi_pick;
    logic lo_found;
    logic [Lg-1:0] lo_pick;

    // Two ascending scans: strictly above last, then from 0 up to last.
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_found = 1'b0;
        lo_pick  = '0;
        for (int i = 0; i < Nr; i++) begin
            if (!hi_found && req[i] && (i > int'(last))) begin
                hi_found = 1'b1;
                hi_pick  = Lg'(i);
            end
            if (!lo_found && req[i] && (i <= int'(last))) begin
                lo_found = 1'b1;
                lo_pick  = Lg'(i);
            end
        end
    end

    assign any  = hi_found | lo_found;
    assign pick = hi_found ? hi_pick : lo_pick;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port among Nr requesters.
// Optional FIFO_ARB_PRIO0_EN: requester 0 wins every arbitration it requests.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int Nb        = NB_DEF,
    parameter int Nr        = NR_DEF,
    parameter int Lg        = LG_DEF,
    parameter int Mb        = MB_DEF,
    parameter int burst_max = BURST_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_write_arbiter_if.master  bus,
    output logic [Lg-1:0]         grant,
    output logic                  grant_active
);

    arb_state_e    state_q, state_d;
    logic [Lg-1:0] grant_q, grant_d;
    logic [Lg-1:0] last_q, last_d;
    logic [Mb-1:0] cnt_q, cnt_d;

    logic [Nr-1:0] req;
    logic [Lg-1:0] pick;
    logic          any;
    logic          sel_valid;
    logic [Nb-1:0] sel_data;
    logic [Nr-1:0] ready_vec;

`ifdef FIFO_ARB_PRIO0_EN
    assign req = bus.in_valid[0] ? Nr'(1) : bus.in_valid;
`else
    assign req = bus.in_valid;
`endif

    rr_pick #(
        .Nr (Nr),
        .Lg (Lg)
    ) u_rr_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = bus.in_data[Nb-1:0];
        ready_vec = '0;
        for (int i = 0; i < Nr; i++) begin
            if (grant_q == Lg'(i)) begin
                sel_valid    = bus.in_valid[i];
                sel_data     = bus.in_data[i*Nb +: Nb];
                ready_vec[i] = bus.fifo_wr_ready;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_d            = last_q;
        cnt_d             = cnt_q;
        bus.fifo_wr_valid = 1'b0;
        bus.fifo_wr_data  = sel_data;
        bus.in_ready      = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Gated so nothing is written on a reset cycle.
                bus.fifo_wr_valid = sel_valid && !reset;
                bus.in_ready      = reset ? '0 : ready_vec;
                if (!sel_valid) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end else if (bus.fifo_wr_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == Mb'(burst_max)) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= Lg'(Nr - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant        = grant_q;
    assign grant_active = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed requester streams,
// expected FIFO writes queued per test and popped by a negedge monitor.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int NB = 8;
    localparam int NR = 4;
    localparam int LG = 2;

    typedef struct packed {
        logic          ga;
        logic [LG-1:0] gr;
        logic          fire;
        logic          wv;
        logic [NR-1:0] rdy;
        logic          rst;
    } smp_t;

    typedef struct packed {
        logic [LG-1:0] req;
        logic [NB-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [LG-1:0] grant;
    logic grant_active;

    fifo_write_arbiter_if #(.Nb(NB), .Nr(NR)) bus ();

    fifo_write_arbiter #(
        .Nb        (NB),
        .Nr        (NR),
        .Lg        (LG),
        .Mb        (4),
        .burst_max (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .grant        (grant),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    smp_t trace[$];
    exp_t exp_q[$];
    logic [NB-1:0] src[NR][$];
    logic [NR-1:0] en = '0;
    logic [NR-1:0] fire_q = '0;
    int stall_lo = 1000;
    int stall_hi = 0;
    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic logic [NB-1:0] wd(int r, int k);
        return NB'(r * 16 + k);
    endfunction

    function automatic int count_fire(int a, int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(trace[i].fire);
        return n;
    endfunction

    // Monitor: record each cycle and score every FIFO write.
    always @(negedge clk) begin
        smp_t s;
        exp_t e;
        logic [NR-1:0] want_rdy;
        s.ga   = grant_active;
        s.gr   = grant;
        s.wv   = bus.fifo_wr_valid;
        s.rdy  = bus.in_ready;
        s.rst  = reset;
        s.fire = bus.fifo_wr_valid && bus.fifo_wr_ready && !reset;
        fire_q = bus.in_valid & bus.in_ready & {NR{!reset}};
        trace.push_back(s);
        want_rdy = (grant_active && !reset) ?
                   (NR'(bus.fifo_wr_ready) << grant) : '0;
        checks++;
        if (bus.in_ready !== want_rdy) begin
            failures++;
            $display("FAIL in_ready actual=%b expected=%b", bus.in_ready, want_rdy);
        end
        if (s.fire) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_extra actual=req%0d/%h expected=none",
                         grant, bus.fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant, bus.fifo_wr_data} !== {e.req, e.data}) begin
                    failures++;
                    $display("FAIL write actual=req%0d/%h expected=req%0d/%h",
                             grant, bus.fifo_wr_data, e.req, e.data);
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.in_valid[i] = en[i] && (src[i].size() > 0);
            bus.in_data[i*NB +: NB] = (src[i].size() > 0) ? src[i][0] : '0;
        end
        bus.fifo_wr_ready = !(trace.size() >= stall_lo && trace.size() <= stall_hi);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (fire_q[i] && src[i].size() > 0) void'(src[i].pop_front());
        drive();
    endtask

    task automatic fill(int r, int n);
        for (int k = 0; k < n; k++) src[r].push_back(wd(r, k));
    endtask

    task automatic expect_burst(int r, int first, int n);
        exp_t e;
        for (int k = first; k < first + n; k++) begin
            e.req  = LG'(r);
            e.data = wd(r, k);
            exp_q.push_back(e);
        end
    endtask

    task automatic begin_test();
        reset = 1'b1;
        en = '0;
        stall_lo = 1000;
        stall_hi = 0;
        for (int i = 0; i < NR; i++) src[i].delete();
        drive();
        tick();
        tick();
        trace.delete();
        exp_q.delete();
    endtask

    task automatic go();
        reset = 1'b0;
        drive();
    endtask

    task automatic run_until(int n);
        int b = 0;
        while (trace.size() < n && b < 300) begin
            tick();
            b++;
        end
        chk("run_len", int'(trace.size() >= n), 1);
    endtask

    initial begin
        // Single requester, 10 words: 8-word burst, bubble, 2 more.
        begin_test();
        fill(1, 10);
        en[1] = 1'b1;
        expect_burst(1, 0, 10);
        go();
        run_until(14);
        chk("t1_rst_ga", int'(trace[0].ga), 0);
        chk("t1_rst_grant", int'(trace[0].gr), 0);
        chk("t1_rst_wv", int'(trace[0].wv), 0);
        chk("t1_rst_rdy", int'(trace[0].rdy), 0);
        chk("t1_first_ga", int'(trace[1].ga), 1);
        chk("t1_first_grant", int'(trace[1].gr), 1);
        chk("t1_burst1", count_fire(1, 8), 8);
        chk("t1_bubble", int'(trace[9].ga), 0);
        chk("t1_regrant", int'(trace[10].gr), 1);
        chk("t1_drop_wv", int'(trace[12].wv), 0);
        chk("t1_total", count_fire(0, 13), 10);
        chk("t1_leftover", exp_q.size(), 0);

        // All four requesters valid from reset.
        begin_test();
        for (int r = 0; r < NR; r++) fill(r, 16);
        en = '1;
`ifdef FIFO_ARB_PRIO0_EN
        expect_burst(0, 0, 16);
        expect_burst(1, 0, 8);
        expect_burst(2, 0, 8);
        expect_burst(3, 0, 8);
`else
        expect_burst(0, 0, 8);
        expect_burst(1, 0, 8);
        expect_burst(2, 0, 8);
        expect_burst(3, 0, 8);
        expect_burst(0, 8, 8);
`endif
        go();
        run_until(46);
`ifdef FIFO_ARB_PRIO0_EN
        chk("t2_g1", int'(trace[10].gr), 0);
        chk("t2_g2", int'(trace[19].gr), 1);
        chk("t2_g3", int'(trace[28].gr), 2);
        chk("t2_g4", int'(trace[37].gr), 3);
`else
        chk("t2_g0", int'(trace[1].gr), 0);
        chk("t2_g1", int'(trace[10].gr), 1);
        chk("t2_g2", int'(trace[19].gr), 2);
        chk("t2_g3", int'(trace[28].gr), 3);
        chk("t2_g4", int'(trace[37].gr), 0);
`endif
        chk("t2_gaps", int'(trace[9].ga) + int'(trace[18].ga) +
            int'(trace[27].ga) + int'(trace[36].ga), 0);
        chk("t2_total", count_fire(0, 45), 40);
        chk("t2_leftover", exp_q.size(), 0);

        // FIFO full for 5 cycles after 3 words of requester 2.
        begin_test();
        fill(2, 8);
        en[2] = 1'b1;
        stall_lo = 4;
        stall_hi = 8;
        expect_burst(2, 0, 8);
        go();
        run_until(15);
        chk("t3_pre", count_fire(1, 3), 3);
        begin
            int ga_n = 0;
            int g2_n = 0;
            int rdy_or = 0;
            for (int i = 4; i <= 8; i++) begin
                ga_n += int'(trace[i].ga);
                g2_n += int'(trace[i].gr == 2);
                rdy_or |= int'(trace[i].rdy);
            end
            chk("t3_stall_ga", ga_n, 5);
            chk("t3_stall_grant", g2_n, 5);
            chk("t3_stall_rdy", rdy_or, 0);
        end
        chk("t3_stall_fire", count_fire(4, 8), 0);
        chk("t3_post", count_fire(9, 13), 5);
        chk("t3_idle", int'(trace[14].ga), 0);
        chk("t3_leftover", exp_q.size(), 0);

        // Requester 1 drops valid after 2 words; requester 3 follows.
        begin_test();
        fill(1, 2);
        fill(3, 3);
        en[1] = 1'b1;
        en[3] = 1'b1;
        expect_burst(1, 0, 2);
        expect_burst(3, 0, 3);
        go();
        run_until(10);
        chk("t4_hold_ga", int'(trace[3].ga), 1);
        chk("t4_no_phantom", int'(trace[3].wv), 0);
        chk("t4_idle", int'(trace[4].ga), 0);
        chk("t4_next_ga", int'(trace[5].ga), 1);
        chk("t4_next_grant", int'(trace[5].gr), 3);
        chk("t4_total", count_fire(0, 9), 5);
        chk("t4_leftover", exp_q.size(), 0);

        // Reset during a burst after 4 words.
        begin_test();
        fill(2, 10);
        fill(1, 8);
        en[2] = 1'b1;
        expect_burst(2, 0, 4);
        go();
        run_until(5);
        reset = 1'b1;
        en[1] = 1'b1;
        expect_burst(1, 0, 8);
        drive();
        tick();
        reset = 1'b0;
        drive();
        run_until(16);
        chk("t5_pre", count_fire(1, 4), 4);
        chk("t5_rst_wv", int'(trace[5].wv), 0);
        chk("t5_rst_rdy", int'(trace[5].rdy), 0);
        chk("t5_after_ga", int'(trace[6].ga), 0);
        chk("t5_after_rdy", int'(trace[6].rdy), 0);
        chk("t5_after_wv", int'(trace[6].wv), 0);
        chk("t5_after_grant", int'(trace[6].gr), 0);
        chk("t5_regrant", int'(trace[7].gr), 1);
        chk("t5_total", count_fire(0, 15), 12);
        chk("t5_leftover", exp_q.size(), 0);

        // Requesters 0 and 3 continuously valid.
        begin_test();
        fill(0, 16);
        fill(3, 16);
        en[0] = 1'b1;
        en[3] = 1'b1;
`ifdef FIFO_ARB_PRIO0_EN
        expect_burst(0, 0, 16);
        expect_burst(3, 0, 8);
`else
        expect_burst(0, 0, 8);
        expect_burst(3, 0, 8);
        expect_burst(0, 8, 8);
`endif
        go();
        run_until(28);
        chk("t6_g0", int'(trace[1].gr), 0);
`ifdef FIFO_ARB_PRIO0_EN
        chk("t6_g1", int'(trace[10].gr), 0);
        chk("t6_g2", int'(trace[19].gr), 3);
`else
        chk("t6_g1", int'(trace[10].gr), 3);
        chk("t6_g2", int'(trace[19].gr), 0);
`endif
        chk("t6_total", count_fire(0, 27), 24);
        chk("t6_leftover", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
